fp_div_param: RTL and testbench



---
 rtl/fp_div_param.sv | 124 ++++++++++++
 tb/tb_fp_div_param.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/fp_div_param.sv
// fp_div_param: iterative parametrised FP divider; define FP_DIV_RNE_EN for round-to-nearest-even, otherwise truncate
module fp_div_param #(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23,
   localparam int W = 1 + EXP_W + MAN_W
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         strt,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic         busy,
   output logic         done,
   output logic [W-1:0] z,
   output logic [3:0]   flags
);
   localparam int EW = EXP_W + 2;
   localparam int CW = $clog2(MAN_W + 3);
   localparam logic signed [EW-1:0] BIAS = EW'((1 << (EXP_W - 1)) - 1);
   localparam logic signed [EW-1:0] EMAX = EW'((1 << EXP_W) - 1);
   localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
   localparam logic [CW-1:0] LAST = CW'(MAN_W + 2);
   typedef enum logic [2:0] {IDLE, UNPACK, DIVIDE, NORM, ROUND, DONE} state_t;
   state_t state, nxt;
   logic [W-1:0] ra, rb, sz, zo, zp;
   logic [EXP_W-1:0] ea, eb;
   logic [MAN_W-1:0] ma, mb, rm;
   logic [MAN_W+1:0] rem, rn;
   logic [MAN_W:0] dvs;
   logic [MAN_W+2:0] q;
   logic signed [EW-1:0] e, re;
   logic [CW-1:0] cnt;
   logic s, a_z, a_i, a_n, b_z, b_i, b_n, special, nan, inv, dz, ge, ovf, unf;
   assign ea = ra[W-2:MAN_W];
   assign eb = rb[W-2:MAN_W];
   assign ma = ra[MAN_W-1:0];
   assign mb = rb[MAN_W-1:0];
   assign s = ra[W-1] ^ rb[W-1];
   assign a_z = ea == '0;
   assign b_z = eb == '0;
   assign a_i = &ea && ma == '0;
   assign b_i = &eb && mb == '0;
   assign a_n = &ea && ma != '0;
   assign b_n = &eb && mb != '0;
   assign special = a_z | a_i | a_n | b_z | b_i | b_n;
   assign nan = a_n | b_n | (a_z & b_z) | (a_i & b_i);
   assign inv = !(a_n | b_n) & ((a_z & b_z) | (a_i & b_i));
   assign dz = !nan & b_z & !a_z & !a_i;
   assign sz = nan ? QNAN : (dz | a_i) ? {s, {EXP_W{1'b1}}, {MAN_W{1'b0}}} : {s, {(W-1){1'b0}}};
   assign ge = rem >= {1'b0, dvs};
   assign rn = ge ? rem - {1'b0, dvs} : rem;
`ifdef FP_DIV_RNE_EN
   logic inc;
   logic [MAN_W+1:0] sum;
   assign inc = q[1] & (q[0] | (rem != '0) | q[2]);
   assign sum = {1'b0, q[MAN_W+2:2]} + (MAN_W+2)'(inc);
   assign rm = sum[MAN_W+1] ? sum[MAN_W:1] : sum[MAN_W-1:0];
   assign re = e + EW'(sum[MAN_W+1]);
   assign zo = {s, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
`else
   assign rm = q[MAN_W+1:2];
   assign re = e;
   assign zo = {s, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
`endif
   assign ovf = !re[EW-1] && re >= EMAX;
   assign unf = re[EW-1] || re == '0;
   assign zp = ovf ? zo : unf ? {s, {(W-1){1'b0}}} : {s, re[EXP_W-1:0], rm};
   assign busy = state != IDLE;
   assign done = state == DONE;
   // state register
   always_ff @(posedge clk)
      state <= reset ? IDLE : nxt;
   // next-state sequencing: specials skip straight to DONE, normal path has fixed length
   always_comb begin
      nxt = state;
      case (state)
         IDLE:    nxt = strt ? UNPACK : IDLE;
         UNPACK:  nxt = special ? DONE : DIVIDE;
         DIVIDE:  nxt = cnt == LAST ? NORM : DIVIDE;
         NORM:    nxt = ROUND;
         ROUND:   nxt = DONE;
         default: nxt = IDLE;
      endcase
   end
   // datapath: operand capture, restoring divide, normalise, round+pack into z/flags
   always_ff @(posedge clk) begin
      if (reset) begin
         z <= '0;
         flags <= '0;
      end else begin
         case (state)
            IDLE: if (strt) begin
               ra <= a;
               rb <= b;
               flags <= '0;
            end
            UNPACK: if (special) begin
               z <= sz;
               flags <= {inv, dz, 2'b00};
            end else begin
               rem <= {2'b01, ma};
               dvs <= {1'b1, mb};
               q <= '0;
               cnt <= '0;
               e <= EW'(ea) - EW'(eb) + BIAS;
            end
            DIVIDE: begin
               rem <= {rn[MAN_W:0], 1'b0};
               q <= {q[MAN_W+1:0], ge};
               cnt <= cnt + CW'(1);
            end
            NORM: if (!q[MAN_W+2]) begin
               q <= q << 1;
               e <= e - EW'(1);
            end
            ROUND: begin
               z <= zp;
               flags <= {2'b00, ovf, unf};
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_fp_div_param.sv
// tb_fp_div_param: directed checks of fp_div_param (single and half precision); honours FP_DIV_RNE_EN
module tb_fp_div_param;
`ifdef FP_DIV_RNE_EN
   localparam logic [31:0] THIRD = 32'h3EAAAAAB;
   localparam logic [31:0] OVF = 32'h7F800000;
   localparam logic [15:0] OVF_H = 16'h7C00;
`else
   localparam logic [31:0] THIRD = 32'h3EAAAAAA;
   localparam logic [31:0] OVF = 32'h7F7FFFFF;
   localparam logic [15:0] OVF_H = 16'h7BFF;
`endif
   logic clk = 0, reset = 1, strt = 0, strt_h = 0;
   logic [31:0] a = 0, b = 0, z;
   logic [15:0] a_h = 0, b_h = 0, z_h;
   logic busy, done, busy_h, done_h;
   logic [3:0] flags, flags_h;
   int total = 0, bad = 0;
   int lat, nd, d1, d2, n, w;
   logic [31:0] z1;
   logic [3:0] f1;
   logic ok, b31, b32;
   always #5 clk = ~clk;
   fp_div_param dut (
      .clk(clk), .reset(reset), .strt(strt), .a(a), .b(b),
      .busy(busy), .done(done), .z(z), .flags(flags)
   );
   fp_div_param #(.EXP_W(5), .MAN_W(10)) dut_h (
      .clk(clk), .reset(reset), .strt(strt_h), .a(a_h), .b(b_h),
      .busy(busy_h), .done(done_h), .z(z_h), .flags(flags_h)
   );
   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", tag, got, exp);
      end
   endtask
   task automatic step;
      @(posedge clk);
      #1;
   endtask
   task automatic run(input bit h, input logic [31:0] av, input logic [31:0] bv,
                      output int l, output logic [31:0] zs, output logic [3:0] fs, output logic hs);
      if (h) begin
         a_h = av[15:0];
         b_h = bv[15:0];
         strt_h = 1;
      end else begin
         a = av;
         b = bv;
         strt = 1;
      end
      step;
      strt = 0;
      strt_h = 0;
      l = 1;
      hs = 1;
      zs = h ? {16'h0, z_h} : z;
      fs = h ? flags_h : flags;
      while (!(h ? done_h : done) && l < 200) begin
         hs &= h ? busy_h : busy;
         step;
         l++;
      end
      hs &= h ? busy_h : busy;
      step;
      hs &= !(h ? busy_h : busy);
   endtask
   initial begin
      repeat (2) step;
      reset = 0;
      chk("rst_z", z, 0);
      chk("rst_flags", flags, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      run(0, 32'h41480000, 32'h40200000, lat, z1, f1, ok);
      chk("div_lat", lat, 30);
      chk("div_z", z, 32'h40A00000);
      chk("div_flags", flags, 0);
      chk("div_busy", ok, 1);
      run(0, 32'h3F800000, 32'h40400000, lat, z1, f1, ok);
      chk("third_z", z, THIRD);
      chk("third_lat", lat, 30);
      run(0, 32'h40C00000, 32'hBFC00000, lat, z1, f1, ok);
      chk("neg_z", z, 32'hC0800000);
      run(0, 32'h3F800000, 32'h00000000, lat, z1, f1, ok);
      chk("dz_z", z, 32'h7F800000);
      chk("dz_flags", flags, 4'b0100);
      chk("dz_lat", lat, 2);
      chk("dz_busy", ok, 1);
      run(0, 32'h00000000, 32'h00000000, lat, z1, f1, ok);
      chk("zz_z", z, 32'h7FC00000);
      chk("zz_flags", flags, 4'b1000);
      run(0, 32'hFF800000, 32'h40000000, lat, z1, f1, ok);
      chk("inf_z", z, 32'hFF800000);
      chk("inf_flags", flags, 0);
      run(0, 32'h7F800001, 32'h3F800000, lat, z1, f1, ok);
      chk("nan_z", z, 32'h7FC00000);
      chk("nan_flags", flags, 0);
      run(0, 32'hC0000000, 32'h7F800000, lat, z1, f1, ok);
      chk("finf_z", z, 32'h80000000);
      run(0, 32'h7F7FFFFF, 32'h3F000000, lat, z1, f1, ok);
      chk("ovf_z", z, OVF);
      chk("ovf_flags", flags, 4'b0010);
      chk("ovf_lat", lat, 30);
      run(0, 32'h00800000, 32'h40000000, lat, z1, f1, ok);
      chk("acc_flags_clr", f1, 0);
      chk("acc_z_held", z1, OVF);
      chk("unf_z", z, 0);
      chk("unf_flags", flags, 4'b0001);
      run(1, 32'h4200, 32'h3C00, lat, z1, f1, ok);
      chk("h_lat", lat, 17);
      chk("h_z", z_h, 16'h4200);
      chk("h_flags", flags_h, 0);
      chk("h_busy", ok, 1);
      run(1, 32'h7BFF, 32'h3800, lat, z1, f1, ok);
      chk("h_ovf_flags", flags_h, 4'b0010);
      chk("h_ovf_z", z_h, OVF_H);
      a = 32'h41480000;
      b = 32'h40200000;
      strt = 1;
      step;
      nd = 0;
      d1 = 0;
      d2 = 0;
      for (int i = 1; i <= 66; i++) begin
         if (done) begin
            nd++;
            if (nd == 1) d1 = i;
            else if (nd == 2) d2 = i;
         end
         if (i == 31) b31 = busy;
         if (i == 32) b32 = busy;
         step;
      end
      strt = 0;
      w = 0;
      while (busy && w < 100) begin
         step;
         w++;
      end
      chk("held_ndone", nd, 2);
      chk("held_d1", d1, 30);
      chk("held_d2", d2, 61);
      chk("held_gap", b31, 0);
      chk("held_reacc", b32, 1);
      chk("held_idle", busy, 0);
      a = 32'h41480000;
      b = 32'h40200000;
      strt = 1;
      step;
      strt = 0;
      n = 1;
      repeat (3) begin
         step;
         n++;
      end
      a = 32'h3F800000;
      b = 32'h40400000;
      strt = 1;
      step;
      n++;
      strt = 0;
      while (!done && n < 100) begin
         step;
         n++;
      end
      chk("ign_lat", n, 30);
      chk("ign_z", z, 32'h40A00000);
      step;
      step;
      chk("ign_busy", busy, 0);
      strt = 1;
      step;
      strt = 0;
      repeat (9) step;
      reset = 1;
      step;
      reset = 0;
      chk("mid_busy", busy, 0);
      chk("mid_z", z, 0);
      chk("mid_flags", flags, 0);
      chk("mid_done", done, 0);
      nd = 0;
      repeat (40) begin
         step;
         if (done) nd++;
      end
      chk("mid_nodone", nd, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
